// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry valid/ready holding register.
//
// Oversamples the asynchronous rx line through a 2-flop synchronizer, finds the
// start-bit centre, samples each data bit (LSB first) and the stop bit at mid-bit,
// and hands the byte to the consumer through a single holding register.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   rx       in   asynchronous serial input, idles high
//   ch_vld   out  holding register contains a byte
//   ch       out  received byte, stable while ch_vld is high
//   ch_rdy   in   consumer accepts the byte (handshake on ch_vld & ch_rdy)
//   frm_err  out  one-cycle pulse: stop bit sampled low, byte discarded
//   ovr_err  out  one-cycle pulse: byte dropped because the holding register was full
//
// CLKS_PER_BIT must be even and at least 4.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       ch_vld,
    output logic [7:0] ch,
    input  logic       ch_rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // Synchronizer, both stages idle high so reset never looks like a start bit.
    logic rx_meta_q;
    logic rx_s_q;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ch_vld_q, ch_vld_d;
    logic [7:0]      ch_q, ch_d;
    logic            frm_err_q, frm_err_d;
    logic            ovr_err_q, ovr_err_d;

    logic            deliver;
    logic            handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        frm_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Start-bit centre: a line that has gone high again was a glitch.
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d        = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                // Decision at mid stop bit, so IDLE re-arms before the bit ends.
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frm_err_d = 1'b1;
                        state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                // Wait out a held-low line so it yields only one framing error.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: a same-cycle handshake frees the slot for the new byte.
    assign handshake = ch_vld_q & ch_rdy;

    always_comb begin
        ch_vld_d  = ch_vld_q & ~handshake;
        ch_d      = ch_q;
        ovr_err_d = 1'b0;
        if (deliver) begin
            if (!ch_vld_q || handshake) begin
                ch_d     = shift_q;
                ch_vld_d = 1'b1;
            end else begin
                ovr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            ch_vld_q  <= 1'b0;
            ch_q      <= 8'h00;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ch_vld_q  <= ch_vld_d;
            ch_q      <= ch_d;
            frm_err_q <= frm_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    assign ch_vld  = ch_vld_q;
    assign ch      = ch_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// A negedge monitor logs ch_vld rising edges and error pulses with their cycle
// numbers; the main sequence drives frames and compares the log against
// hand-computed expectations (delivery at E+154, back-to-back spacing 10*C).
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ch_vld;
    logic [7:0] ch;
    logic       ch_rdy = 1'b1;
    logic       frm_err;
    logic       ovr_err;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;

    // Monitor log.
    int         vld_n;
    int         vld_hi;
    int         vld_cyc [8];
    logic [7:0] vld_ch  [8];
    int         frm_n;
    int         frm_cyc;
    int         ovr_n;
    int         ovr_cyc;
    logic       vld_prev = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .ch_vld (ch_vld),
        .ch     (ch),
        .ch_rdy (ch_rdy),
        .frm_err(frm_err),
        .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ch_vld && !vld_prev) begin
            if (vld_n < 8) begin
                vld_cyc[vld_n] = cyc;
                vld_ch[vld_n]  = ch;
            end
            vld_n++;
        end
        if (ch_vld) vld_hi++;
        if (frm_err) begin
            frm_n++;
            frm_cyc = cyc;
        end
        if (ovr_err) begin
            ovr_n++;
            ovr_cyc = cyc;
        end
        vld_prev = ch_vld;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        vld_n   = 0;
        vld_hi  = 0;
        frm_n   = 0;
        frm_cyc = -1;
        ovr_n   = 0;
        ovr_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            vld_cyc[i] = -1;
            vld_ch[i]  = 8'h00;
        end
    endtask

    // Called just after a clock edge; e is the edge at which the first sync flop
    // captures the start bit. Returns just after the stop bit's last cycle.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int e);
        rx = 1'b0;
        e  = cyc + 1;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            tick(C);
        end
        rx = stop_bit;
        tick(C);
    endtask

    int e0, e1, e2;

    initial begin
        clear_mon();

        // Reset state
        tick(3);
        check("rst_ch_vld", 32'(ch_vld), 32'd0);
        check("rst_ch", 32'(ch), 32'h00);
        check("rst_frm_err", 32'(frm_err), 32'd0);
        check("rst_ovr_err", 32'(ovr_err), 32'd0);
        rst = 1'b0;
        tick(5);

        // 0x55 with ch_rdy held high
        clear_mon();
        ch_rdy = 1'b1;
        send_frame(8'h55, 1'b1, e0);
        tick(4);
        check("t1_vld_count", 32'(vld_n), 32'd1);
        check("t1_vld_cycle", 32'(vld_cyc[0]), 32'(e0 + 154));
        check("t1_ch", 32'(vld_ch[0]), 32'h55);
        check("t1_vld_width", 32'(vld_hi), 32'd1);
        check("t1_no_errs", 32'(frm_n + ovr_n), 32'd0);

        // Start-bit glitch, then 0xA5
        clear_mon();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        check("t2_glitch_vld", 32'(vld_n), 32'd0);
        check("t2_glitch_errs", 32'(frm_n + ovr_n), 32'd0);
        send_frame(8'hA5, 1'b1, e0);
        tick(4);
        check("t2_vld_count", 32'(vld_n), 32'd1);
        check("t2_ch", 32'(vld_ch[0]), 32'hA5);
        check("t2_vld_cycle", 32'(vld_cyc[0]), 32'(e0 + 154));

        // Framing error with line held low, then 0x3C
        clear_mon();
        send_frame(8'hA3, 1'b0, e0);
        tick(40);
        rx = 1'b1;
        tick(10);
        check("t3_frm_count", 32'(frm_n), 32'd1);
        check("t3_frm_cycle", 32'(frm_cyc), 32'(e0 + 154));
        check("t3_no_vld", 32'(vld_n), 32'd0);
        check("t3_no_ovr", 32'(ovr_n), 32'd0);
        clear_mon();
        send_frame(8'h3C, 1'b1, e0);
        tick(4);
        check("t3_next_vld", 32'(vld_n), 32'd1);
        check("t3_next_ch", 32'(vld_ch[0]), 32'h3C);
        check("t3_next_no_frm", 32'(frm_n), 32'd0);

        // Overrun with ch_rdy low
        clear_mon();
        ch_rdy = 1'b0;
        send_frame(8'h11, 1'b1, e0);
        tick(5);
        send_frame(8'h22, 1'b1, e1);
        tick(4);
        check("t4_ch_held", 32'(ch), 32'h11);
        check("t4_ch_vld", 32'(ch_vld), 32'd1);
        check("t4_vld_rises", 32'(vld_n), 32'd1);
        check("t4_ovr_count", 32'(ovr_n), 32'd1);
        check("t4_ovr_cycle", 32'(ovr_cyc), 32'(e1 + 154));
        ch_rdy = 1'b1;
        tick(1);
        ch_rdy = 1'b0;
        check("t4_hs_vld", 32'(ch_vld), 32'd0);
        check("t4_hs_ch", 32'(ch), 32'h11);

        // Back-to-back frames
        clear_mon();
        ch_rdy = 1'b1;
        send_frame(8'h00, 1'b1, e0);
        send_frame(8'hFF, 1'b1, e1);
        send_frame(8'h81, 1'b1, e2);
        tick(4);
        check("t5_vld_count", 32'(vld_n), 32'd3);
        check("t5_first_cycle", 32'(vld_cyc[0]), 32'(e0 + 154));
        check("t5_gap01", 32'(vld_cyc[1] - vld_cyc[0]), 32'(10 * C));
        check("t5_gap12", 32'(vld_cyc[2] - vld_cyc[1]), 32'(10 * C));
        check("t5_ch0", 32'(vld_ch[0]), 32'h00);
        check("t5_ch1", 32'(vld_ch[1]), 32'hFF);
        check("t5_ch2", 32'(vld_ch[2]), 32'h81);
        check("t5_no_errs", 32'(frm_n + ovr_n), 32'd0);

        // Reset during data bit 3 with a byte held
        ch_rdy = 1'b0;
        send_frame(8'h99, 1'b1, e0);
        tick(4);
        check("t6_pre_vld", 32'(ch_vld), 32'd1);
        clear_mon();
        fork
            send_frame(8'hF8, 1'b1, e1);
            begin
                tick(4 * C + 8);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                check("t6_rst_vld", 32'(ch_vld), 32'd0);
                check("t6_rst_ch", 32'(ch), 32'h00);
                check("t6_rst_frm", 32'(frm_err), 32'd0);
                check("t6_rst_ovr", 32'(ovr_err), 32'd0);
            end
        join
        tick(20);
        check("t6_no_stray_vld", 32'(vld_n), 32'd0);
        check("t6_no_stray_frm", 32'(frm_n), 32'd0);
        ch_rdy = 1'b1;
        send_frame(8'h5A, 1'b1, e2);
        tick(4);
        check("t6_vld_count", 32'(vld_n), 32'd1);
        check("t6_ch", 32'(vld_ch[0]), 32'h5A);
        check("t6_vld_cycle", 32'(vld_cyc[0]), 32'(e2 + 154));
        check("t6_no_frm", 32'(frm_n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
